// File: rtl/svga_timing_pkg.sv
// Shared widths, default 640x480 timing set, mode payload and total-length helpers
// for the parametrised SVGA timing generator.
package svga_timing_pkg;

  localparam int unsigned PIX_W     = 11;
  localparam int unsigned LINE_W    = 10;
  localparam int unsigned SUBPIX_W  = 4;
  localparam int unsigned SUBLINE_W = 5;
  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned GPIX_W    = 9;
  localparam int unsigned GROW_W    = 8;
  localparam int unsigned GREP_W    = 2;
  localparam int unsigned FRAME_W   = 8;

  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_H_FP         = 16;
  localparam int unsigned DEF_H_SYNC       = 96;
  localparam int unsigned DEF_H_BP         = 48;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_V_FP         = 10;
  localparam int unsigned DEF_V_SYNC       = 2;
  localparam int unsigned DEF_V_BP         = 33;
  localparam int unsigned DEF_H_BORDER     = 64;
  localparam int unsigned DEF_V_BORDER     = 48;
  localparam int unsigned DEF_DECODE_DELAY = 7;
  localparam bit          DEF_HSYNC_POL    = 1'b1;
  localparam bit          DEF_VSYNC_POL    = 1'b1;

  // Run-time mode, shadowed once per frame
  typedef struct packed {
    logic                 cell_narrow;
    logic [SUBLINE_W-1:0] cell_h_m1;
    logic [GREP_W-1:0]    vscale_m1;
  } mode_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/svga_sync_counter.sv
// Wrapping position counter with registered blank and sync flags aligned to the count.
module svga_sync_counter #(
  parameter int unsigned W       = 11,
  parameter int unsigned TOTAL   = 800,
  parameter int unsigned ACTIVE  = 640,
  parameter int unsigned SYNC_LO = 656,
  parameter int unsigned SYNC_HI = 751,
  parameter bit          POL     = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_next_c_o,
  output logic         blank_o,
  output logic         sync_o
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT    = W'(ACTIVE);
  localparam logic [W-1:0] S_LO   = W'(SYNC_LO);
  localparam logic [W-1:0] S_HI   = W'(SYNC_HI);

  logic [W-1:0] count_q, count_d;
  logic         blank_q, blank_d;
  logic         sync_q, sync_d;

  // Flags are decoded from the next count so they line up with count_o
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
    blank_d = (count_d >= ACT);
    sync_d  = ((count_d >= S_LO) && (count_d <= S_HI)) ? POL : ~POL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o        = count_q;
  assign count_next_c_o = count_d;
  assign blank_o        = blank_q;
  assign sync_o         = sync_q;

endmodule

// File: rtl/svga_timing_gen_param.sv
// Programmable video timing generator: H/V sync and blank, border window, and the
// text-cell and scaled-graphics fetch counters for the VRAM/font/palette pipeline.
module svga_timing_gen_param
  import svga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned H_BORDER     = DEF_H_BORDER,
  parameter int unsigned V_BORDER     = DEF_V_BORDER,
  parameter int unsigned DECODE_DELAY = DEF_DECODE_DELAY,
  parameter bit          HSYNC_POL    = DEF_HSYNC_POL,
  parameter bit          VSYNC_POL    = DEF_VSYNC_POL
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  input  logic                 cell_narrow,
  input  logic [SUBLINE_W-1:0] cell_h_m1,
  input  logic [GREP_W-1:0]    vscale_m1,
  output logic                 h_synch,
  output logic                 v_synch,
  output logic                 h_blank,
  output logic                 v_blank,
  output logic [PIX_W-1:0]     pixel_count,
  output logic [LINE_W-1:0]    line_count,
  output logic                 show_border,
  output logic [SUBPIX_W-1:0]  subchar_pixel,
  output logic [SUBLINE_W-1:0] subchar_line,
  output logic [CHAR_W-1:0]    char_column,
  output logic [CHAR_W-1:0]    char_line,
  output logic [GPIX_W-1:0]    graph_pixel,
  output logic [GROW_W-1:0]    graph_row,
  output logic [GREP_W-1:0]    graph_rep,
  output logic                 frame_start,
  output logic [FRAME_W-1:0]   frame_count
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("svga_timing_gen_param: H_TOTAL must not exceed 2048");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("svga_timing_gen_param: V_TOTAL must not exceed 1024");
  end
  if (H_BORDER < DECODE_DELAY) begin : g_border_chk
    $error("svga_timing_gen_param: H_BORDER must be at least DECODE_DELAY");
  end

  localparam logic [PIX_W-1:0]  H_LAST   = PIX_W'(H_TOTAL - 1);
  localparam logic [PIX_W-1:0]  H_ACT_LAST = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0]  FETCH_LO = PIX_W'(H_BORDER - DECODE_DELAY);
  localparam logic [PIX_W-1:0]  FETCH_HI = PIX_W'(H_ACTIVE - H_BORDER - DECODE_DELAY - 1);
  localparam logic [PIX_W-1:0]  X_LO     = PIX_W'(H_BORDER);
  localparam logic [PIX_W-1:0]  X_HI     = PIX_W'(H_ACTIVE - H_BORDER - 1);
  localparam logic [LINE_W-1:0] V_LAST   = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] Y_LO     = LINE_W'(V_BORDER);
  localparam logic [LINE_W-1:0] Y_HI     = LINE_W'(V_ACTIVE - V_BORDER - 1);

  logic [PIX_W-1:0]  pixel_next;
  logic [LINE_W-1:0] line_next;
  logic              h_last, frame_last, show_line, fetch_en;
  logic [SUBPIX_W-1:0] cell_wrap;
  mode_t             mode_in, mode_q, mode_d;

  logic [SUBPIX_W-1:0]  subchar_pixel_q, subchar_pixel_d;
  logic [CHAR_W-1:0]    char_column_q, char_column_d;
  logic [GPIX_W-1:0]    graph_pixel_q, graph_pixel_d;
  logic [SUBLINE_W-1:0] subchar_line_q, subchar_line_d;
  logic [CHAR_W-1:0]    char_line_q, char_line_d;
  logic [GROW_W-1:0]    graph_row_q, graph_row_d;
  logic [GREP_W-1:0]    graph_rep_q, graph_rep_d;
  logic                 show_border_q, show_border_d;
  logic                 frame_start_q, frame_start_d;
  logic [FRAME_W-1:0]   frame_count_q, frame_count_d;

  assign mode_in = '{cell_narrow: cell_narrow, cell_h_m1: cell_h_m1, vscale_m1: vscale_m1};

  svga_sync_counter #(
    .W      (PIX_W),
    .TOTAL  (H_TOTAL),
    .ACTIVE (H_ACTIVE),
    .SYNC_LO(H_ACTIVE + H_FP),
    .SYNC_HI(H_ACTIVE + H_FP + H_SYNC - 1),
    .POL    (HSYNC_POL)
  ) u_h_cnt (
    .clk_i         (pixel_clock),
    .rst_i         (reset),
    .en_i          (1'b1),
    .count_o       (pixel_count),
    .count_next_c_o(pixel_next),
    .blank_o       (h_blank),
    .sync_o        (h_synch)
  );

  svga_sync_counter #(
    .W      (LINE_W),
    .TOTAL  (V_TOTAL),
    .ACTIVE (V_ACTIVE),
    .SYNC_LO(V_ACTIVE + V_FP),
    .SYNC_HI(V_ACTIVE + V_FP + V_SYNC - 1),
    .POL    (VSYNC_POL)
  ) u_v_cnt (
    .clk_i         (pixel_clock),
    .rst_i         (reset),
    .en_i          (h_last),
    .count_o       (line_count),
    .count_next_c_o(line_next),
    .blank_o       (v_blank),
    .sync_o        (v_synch)
  );

  always_comb begin
    h_last     = (pixel_count == H_LAST);
    frame_last = h_last && (line_count == V_LAST);
    show_line  = (line_count >= Y_LO) && (line_count <= Y_HI);
    fetch_en   = show_line && (pixel_count >= FETCH_LO) && (pixel_count <= FETCH_HI);
    cell_wrap  = mode_q.cell_narrow ? SUBPIX_W'(7) : SUBPIX_W'(15);
  end

  // Next-state for shadows, fetch counters, border and frame markers
  always_comb begin
    mode_d          = mode_q;
    subchar_pixel_d = subchar_pixel_q;
    char_column_d   = char_column_q;
    graph_pixel_d   = graph_pixel_q;
    subchar_line_d  = subchar_line_q;
    char_line_d     = char_line_q;
    graph_row_d     = graph_row_q;
    graph_rep_d     = graph_rep_q;

    if (frame_last) begin
      mode_d = mode_in;
    end

    if (pixel_count == H_ACT_LAST) begin
      subchar_pixel_d = '0;
      char_column_d   = '0;
      graph_pixel_d   = '0;
    end else if (fetch_en) begin
      graph_pixel_d = graph_pixel_q + GPIX_W'(1);
      if (subchar_pixel_q == cell_wrap) begin
        subchar_pixel_d = '0;
        char_column_d   = char_column_q + CHAR_W'(1);
      end else begin
        subchar_pixel_d = subchar_pixel_q + SUBPIX_W'(1);
      end
    end

    if (h_last) begin
      if (line_next == Y_LO) begin
        subchar_line_d = '0;
        char_line_d    = '0;
        graph_row_d    = '0;
        graph_rep_d    = '0;
      end else if (show_line) begin
        if (subchar_line_q == mode_q.cell_h_m1) begin
          subchar_line_d = '0;
          char_line_d    = char_line_q + CHAR_W'(1);
        end else begin
          subchar_line_d = subchar_line_q + SUBLINE_W'(1);
        end
        if (graph_rep_q == mode_q.vscale_m1) begin
          graph_rep_d = '0;
          graph_row_d = graph_row_q + GROW_W'(1);
        end else begin
          graph_rep_d = graph_rep_q + GREP_W'(1);
        end
      end
    end

    show_border_d = !((line_next >= Y_LO) && (line_next <= Y_HI) &&
                      (pixel_next >= X_LO) && (pixel_next <= X_HI));
    frame_start_d = (pixel_next == '0) && (line_next == '0);
    frame_count_d = frame_start_d ? frame_count_q + FRAME_W'(1) : frame_count_q;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      mode_q          <= mode_in;
      subchar_pixel_q <= '0;
      char_column_q   <= '0;
      graph_pixel_q   <= '0;
      subchar_line_q  <= '0;
      char_line_q     <= '0;
      graph_row_q     <= '0;
      graph_rep_q     <= '0;
      show_border_q   <= 1'b1;
      frame_start_q   <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      mode_q          <= mode_d;
      subchar_pixel_q <= subchar_pixel_d;
      char_column_q   <= char_column_d;
      graph_pixel_q   <= graph_pixel_d;
      subchar_line_q  <= subchar_line_d;
      char_line_q     <= char_line_d;
      graph_row_q     <= graph_row_d;
      graph_rep_q     <= graph_rep_d;
      show_border_q   <= show_border_d;
      frame_start_q   <= frame_start_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign subchar_pixel = subchar_pixel_q;
  assign char_column   = char_column_q;
  assign graph_pixel   = graph_pixel_q;
  assign subchar_line  = subchar_line_q;
  assign char_line     = char_line_q;
  assign graph_row     = graph_row_q;
  assign graph_rep     = graph_rep_q;
  assign show_border   = show_border_q;
  assign frame_start   = frame_start_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_svga_timing_gen_param.sv
// Directed bench for svga_timing_gen_param on a reduced 200x48 timing so several
// frames fit in a short run; expected values are hand-derived from the geometry.
module tb_svga_timing_gen_param;

  // 160+8+16+16 = 200 pixels/line, 40+2+2+4 = 48 lines/frame
  localparam int HT    = 200;
  localparam int VT    = 48;
  localparam int LIMIT = 2 * HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        cell_narrow;
  logic [4:0]  cell_h_m1;
  logic [1:0]  vscale_m1;
  logic        h_synch, v_synch, h_blank, v_blank;
  logic [10:0] pixel_count;
  logic [9:0]  line_count;
  logic        show_border;
  logic [3:0]  subchar_pixel;
  logic [4:0]  subchar_line;
  logic [6:0]  char_column, char_line;
  logic [8:0]  graph_pixel;
  logic [7:0]  graph_row;
  logic [1:0]  graph_rep;
  logic        frame_start;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;
  int pp = 0;
  int pl = 0;

  always #5 clk = ~clk;

  svga_timing_gen_param #(
    .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .H_BORDER(16), .V_BORDER(4), .DECODE_DELAY(7),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut (
    .pixel_clock  (clk),
    .reset        (reset),
    .cell_narrow  (cell_narrow),
    .cell_h_m1    (cell_h_m1),
    .vscale_m1    (vscale_m1),
    .h_synch      (h_synch),
    .v_synch      (v_synch),
    .h_blank      (h_blank),
    .v_blank      (v_blank),
    .pixel_count  (pixel_count),
    .line_count   (line_count),
    .show_border  (show_border),
    .subchar_pixel(subchar_pixel),
    .subchar_line (subchar_line),
    .char_column  (char_column),
    .char_line    (char_line),
    .graph_pixel  (graph_pixel),
    .graph_row    (graph_row),
    .graph_rep    (graph_rep),
    .frame_start  (frame_start),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock, then advance the bench's own raster position
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) begin
      pp = 0;
      pl = 0;
    end else if (pp == HT - 1) begin
      pp = 0;
      pl = (pl == VT - 1) ? 0 : pl + 1;
    end else begin
      pp++;
    end
  endtask

  task automatic goto(input int l, input int p);
    int n;
    n = 0;
    while (!(pl == l && pp == p) && n < LIMIT) begin
      step();
      n++;
    end
    check("goto_in_bound", 32'(n < LIMIT), 32'd1);
    check("pixel_count", 32'(pixel_count), 32'(p));
    check("line_count", 32'(line_count), 32'(l));
  endtask

  initial begin
    reset       = 1'b1;
    cell_narrow = 1'b0;
    cell_h_m1   = 5'd23;
    vscale_m1   = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", 32'(pixel_count), 0);
    check("rst_line", 32'(line_count), 0);
    check("rst_h_synch", 32'(h_synch), 0);
    check("rst_v_synch", 32'(v_synch), 1);
    check("rst_h_blank", 32'(h_blank), 0);
    check("rst_v_blank", 32'(v_blank), 0);
    check("rst_show_border", 32'(show_border), 1);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_char_column", 32'(char_column), 0);
    check("rst_subchar_line", 32'(subchar_line), 0);
    check("rst_graph_row", 32'(graph_row), 0);

    reset = 1'b0;
    step();
    check("pixel_after_release", 32'(pixel_count), 1);

    // Frame 0: wide 16-px cells, 24-line cells, 3x vertical scale
    goto(0, 159); check("h_blank_159", 32'(h_blank), 0);
    goto(0, 160); check("h_blank_160", 32'(h_blank), 1);
    goto(0, 167); check("h_synch_167", 32'(h_synch), 0);
    goto(0, 168); check("h_synch_168", 32'(h_synch), 1);
    goto(0, 183); check("h_synch_183", 32'(h_synch), 1);
    goto(0, 184); check("h_synch_184", 32'(h_synch), 0);
    check("v_blank_line0", 32'(v_blank), 0);
    check("v_synch_line0", 32'(v_synch), 1);
    goto(3, 50);  check("border_line3", 32'(show_border), 1);
    goto(4, 9);
    check("subpix_first_fetch", 32'(subchar_pixel), 0);
    check("col_first_fetch", 32'(char_column), 0);
    check("gpix_first_fetch", 32'(graph_pixel), 0);
    check("subline_line4", 32'(subchar_line), 0);
    goto(4, 10);
    check("subpix_second", 32'(subchar_pixel), 1);
    check("gpix_second", 32'(graph_pixel), 1);
    goto(4, 15);  check("border_px15", 32'(show_border), 1);
    goto(4, 16);  check("border_px16", 32'(show_border), 0);
    goto(4, 136);
    check("col_last_fetch_wide", 32'(char_column), 7);
    check("subpix_last_fetch_wide", 32'(subchar_pixel), 15);
    check("gpix_last_fetch", 32'(graph_pixel), 127);
    goto(4, 137);
    check("col_after_fetch_wide", 32'(char_column), 8);
    check("subpix_wrap_wide", 32'(subchar_pixel), 0);
    goto(4, 143); check("border_px143", 32'(show_border), 0);
    goto(4, 144); check("border_px144", 32'(show_border), 1);
    goto(4, 160);
    check("col_cleared", 32'(char_column), 0);
    check("gpix_cleared", 32'(graph_pixel), 0);
    goto(20, 0);
    check("grow_line20_x3", 32'(graph_row), 5);
    check("grep_line20_x3", 32'(graph_rep), 1);
    // Mid-frame mode change must not act until the next frame
    cell_narrow = 1'b1;
    cell_h_m1   = 5'd7;
    vscale_m1   = 2'd0;
    goto(27, 50);
    check("subline_23", 32'(subchar_line), 23);
    check("charline_before_wrap", 32'(char_line), 0);
    goto(28, 50);
    check("subline_wrap", 32'(subchar_line), 0);
    check("charline_after_wrap", 32'(char_line), 1);
    goto(28, 136);
    check("col_still_wide", 32'(char_column), 7);
    check("subpix_still_wide", 32'(subchar_pixel), 15);
    goto(35, 50);
    check("charline_line35", 32'(char_line), 1);
    check("subline_line35", 32'(subchar_line), 7);
    check("border_line35", 32'(show_border), 0);
    goto(36, 50);
    check("border_line36", 32'(show_border), 1);
    check("grow_final", 32'(graph_row), 10);
    check("grep_final", 32'(graph_rep), 2);
    check("subline_line36", 32'(subchar_line), 8);
    goto(39, 0);  check("v_blank_39", 32'(v_blank), 0);
    goto(40, 0);  check("v_blank_40", 32'(v_blank), 1);
    goto(41, 0);  check("v_synch_41", 32'(v_synch), 1);
    goto(42, 0);  check("v_synch_42", 32'(v_synch), 0);
    goto(43, 199); check("v_synch_43", 32'(v_synch), 0);
    goto(44, 0);  check("v_synch_44", 32'(v_synch), 1);
    goto(47, 199);
    check("fs_last_pixel", 32'(frame_start), 0);
    check("fc_last_pixel", 32'(frame_count), 0);
    goto(0, 0);
    check("fs_wrap", 32'(frame_start), 1);
    check("fc_wrap", 32'(frame_count), 1);
    goto(0, 1);
    check("fs_one_cycle", 32'(frame_start), 0);
    check("fc_hold", 32'(frame_count), 1);
    goto(3, 0);
    check("charline_held", 32'(char_line), 1);
    check("subline_held", 32'(subchar_line), 8);
    check("grow_held", 32'(graph_row), 10);

    // Frame 1: narrow 8-px cells, 8-line cells, 1x scale
    goto(4, 0);
    check("charline_clear", 32'(char_line), 0);
    check("subline_clear", 32'(subchar_line), 0);
    check("grow_clear", 32'(graph_row), 0);
    check("grep_clear", 32'(graph_rep), 0);
    goto(4, 136);
    check("col_last_fetch_narrow", 32'(char_column), 15);
    check("subpix_last_fetch_narrow", 32'(subchar_pixel), 7);
    goto(4, 137);
    check("col_after_fetch_narrow", 32'(char_column), 16);
    check("subpix_wrap_narrow", 32'(subchar_pixel), 0);
    goto(20, 0);
    check("grow_line20_x1", 32'(graph_row), 16);
    check("grep_line20_x1", 32'(graph_rep), 0);
    goto(35, 0);
    check("charline_narrow", 32'(char_line), 3);
    check("subline_narrow", 32'(subchar_line), 7);
    cell_narrow = 1'b0;
    cell_h_m1   = 5'd23;
    vscale_m1   = 2'd2;

    // Mid-frame reset: position restarts and shadows reload immediately
    goto(40, 100);
    reset = 1'b1;
    step();
    check("midrst_pixel", 32'(pixel_count), 0);
    check("midrst_line", 32'(line_count), 0);
    check("midrst_fc", 32'(frame_count), 0);
    check("midrst_fs", 32'(frame_start), 0);
    check("midrst_v_blank", 32'(v_blank), 0);
    check("midrst_border", 32'(show_border), 1);
    reset = 1'b0;
    step();
    check("midrst_pixel_release", 32'(pixel_count), 1);
    goto(20, 0);
    check("grow_after_rst", 32'(graph_row), 5);
    check("grep_after_rst", 32'(graph_rep), 1);
    goto(28, 136);
    check("col_after_rst", 32'(char_column), 7);
    check("subpix_after_rst", 32'(subchar_pixel), 15);
    check("charline_after_rst", 32'(char_line), 1);
    check("subline_after_rst", 32'(subchar_line), 0);
    goto(0, 0);
    check("fs_after_rst", 32'(frame_start), 1);
    check("fc_after_rst", 32'(frame_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
